// File: rtl/axis_query_framer.sv
// Frames signed raw samples into fixed-length AXI-Stream query packets (tuser on first beat, tlast on last).
// Optional saturation of each sample before sign-extension: define AXIS_QUERY_FRAMER_CLAMP_EN.
module axis_query_framer #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int LEN_WIDTH = 16,
  parameter int CNT_WIDTH = 16,
  parameter int CLAMP_LO  = -2048,
  parameter int CLAMP_HI  = 2047
) (
  input  logic                 S_AXIS_clk,
  input  logic                 S_AXIS_rst,
  input  logic                 S_AXIS_tvalid,
  output logic                 S_AXIS_tready,
  input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
  output logic                 M_AXIS_tvalid,
  input  logic                 M_AXIS_tready,
  output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
  output logic                 M_AXIS_tuser,
  output logic                 M_AXIS_tlast,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LEN_WIDTH-1:0] query_len,
  output logic                 busy,
  output logic                 len_err,
  output logic [CNT_WIDTH-1:0] frame_count
);

  if (OUT_WIDTH < IN_WIDTH || CLAMP_LO > CLAMP_HI) begin : g_param_check
    $error("axis_query_framer: OUT_WIDTH must be >= IN_WIDTH and CLAMP_LO <= CLAMP_HI");
  end

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  typedef struct packed {
    logic                 valid;
    logic [OUT_WIDTH-1:0] data;
    logic                 user;
    logic                 last;
  } beat_t;

`ifdef AXIS_QUERY_FRAMER_CLAMP_EN
  localparam logic signed [IN_WIDTH-1:0] LO = IN_WIDTH'(CLAMP_LO);
  localparam logic signed [IN_WIDTH-1:0] HI = IN_WIDTH'(CLAMP_HI);

  function automatic logic signed [IN_WIDTH-1:0] shape(input logic signed [IN_WIDTH-1:0] s);
    if (s < LO) return LO;
    if (s > HI) return HI;
    return s;
  endfunction
`else
  function automatic logic signed [IN_WIDTH-1:0] shape(input logic signed [IN_WIDTH-1:0] s);
    return s;
  endfunction
`endif

  state_t               state, state_nx;
  beat_t                head, skid, head_nx, skid_nx, in_beat;
  logic [LEN_WIDTH-1:0] idx, idx_nx, len_q, len_nx;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 tready_q, tready_nx, busy_q, busy_nx, len_err_q, len_err_nx;
  logic                 start_ok, in_acc, out_hs, last_idx, last_in, abort_hit;

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge S_AXIS_clk or negedge S_AXIS_rst) begin
    if (!S_AXIS_rst) state <= IDLE;
    else             state <= state_nx;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: each always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_ok)          state_nx = STREAM;
      STREAM:  if (last_in || abort)  state_nx = DRAIN;
      DRAIN:   if (!head.valid)       state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  // ---------------- FSM: registered-output next values ----------------
  always_comb begin
    tready_nx  = (state_nx == STREAM) && !skid_nx.valid;
    busy_nx    = (state_nx != IDLE) || head_nx.valid;
    len_err_nx = (state == IDLE) && start && (query_len == '0);
  end

  // ---------------- Datapath: two-entry skid (head drives M_AXIS) ----------------
  always_comb begin
    start_ok  = (state == IDLE) && start && (query_len != '0);
    in_acc    = S_AXIS_tvalid && tready_q;
    out_hs    = head.valid && M_AXIS_tready;
    last_idx  = (idx == len_q - LEN_WIDTH'(1));
    last_in   = in_acc && last_idx;
    abort_hit = abort && (state == STREAM) && !last_in;

    in_beat = '{valid: 1'b1, data: OUT_WIDTH'(shape(S_AXIS_tdata)),
                user: (idx == '0), last: last_idx};

    head_nx = head;
    skid_nx = skid;
    if (out_hs) begin
      head_nx = skid;
      skid_nx = '0;
    end
    if (in_acc) begin
      if (!head_nx.valid) head_nx = in_beat;
      else                skid_nx = in_beat;
    end

    // A beat already on the bus and stalled must not change, so it gets a zero terminator behind it.
    if (abort_hit) begin
      if (skid_nx.valid)
        skid_nx.last = 1'b1;
      else if (head.valid && !out_hs)
        skid_nx = '{valid: 1'b1, data: '0, user: 1'b0, last: 1'b1};
      else if (head_nx.valid)
        head_nx.last = 1'b1;
      else
        head_nx = '{valid: 1'b1, data: '0, user: (idx == '0), last: 1'b1};
    end

    idx_nx = idx;
    len_nx = len_q;
    if (start_ok) begin
      idx_nx = '0;
      len_nx = query_len;
    end else if (in_acc) begin
      idx_nx = idx + LEN_WIDTH'(1);
    end
  end

  // NOTE: buffer entries are reset too, since every output must read 0 out of reset.
  always_ff @(posedge S_AXIS_clk or negedge S_AXIS_rst) begin
    if (!S_AXIS_rst) begin
      head      <= '0;
      skid      <= '0;
      idx       <= '0;
      len_q     <= '0;
      tready_q  <= 1'b0;
      busy_q    <= 1'b0;
      len_err_q <= 1'b0;
      count_q   <= '0;
    end else begin
      head      <= head_nx;
      skid      <= skid_nx;
      idx       <= idx_nx;
      len_q     <= len_nx;
      tready_q  <= tready_nx;
      busy_q    <= busy_nx;
      len_err_q <= len_err_nx;
      if (out_hs && head.last) count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign S_AXIS_tready = tready_q;
  assign M_AXIS_tvalid = head.valid;
  assign M_AXIS_tdata  = head.data;
  assign M_AXIS_tuser  = head.user;
  assign M_AXIS_tlast  = head.last;
  assign busy          = busy_q;
  assign len_err       = len_err_q;
  assign frame_count   = count_q;

endmodule

// File: tb/tb_axis_query_framer.sv
// Bench for axis_query_framer: a queue-based frame model checked every cycle, plus directed literal checks.
module tb_axis_query_framer;

  localparam int IW = 16;
  localparam int OW = 32;
  localparam int LW = 16;
  localparam int CW = 8;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          user;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_tvalid, s_tready;
  logic [IW-1:0] s_tdata;
  logic          m_tvalid, m_tready, m_tuser, m_tlast;
  logic [OW-1:0] m_tdata;
  logic          start, abort, busy, len_err;
  logic [LW-1:0] query_len;
  logic [CW-1:0] frame_count;
  logic          toggle_en;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axis_query_framer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .S_AXIS_clk(clk), .S_AXIS_rst(rst_n),
    .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready), .S_AXIS_tdata(s_tdata),
    .M_AXIS_tvalid(m_tvalid), .M_AXIS_tready(m_tready), .M_AXIS_tdata(m_tdata),
    .M_AXIS_tuser(m_tuser), .M_AXIS_tlast(m_tlast),
    .start(start), .abort(abort), .query_len(query_len),
    .busy(busy), .len_err(len_err), .frame_count(frame_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] model_data(input logic [IW-1:0] raw);
    int v;
    v = int'($signed(raw));
`ifdef AXIS_QUERY_FRAMER_CLAMP_EN
    if (v < -2048) v = -2048;
    if (v > 2047)  v = 2047;
`endif
    return OW'(v);
  endfunction

  // ---------------- model: frame rules as a queue of pending beats ----------------
  beat_t         mq[$];
  beat_t         obs[$];
  int            m_state;   // 0 idle, 1 streaming, 2 draining
  int            m_len, m_idx;
  logic [CW-1:0] m_fc;
  logic          m_lenerr;

  function automatic beat_t obs_at(input int i);
    if (i < obs.size()) return obs[i];
    return '0;
  endfunction

  always @(negedge clk) begin
    beat_t b;
    bit exp_valid, exp_ready, exp_busy, in_acc, out_hs, last_in;
    int pre_size;
    if (!rst_n) begin
      mq.delete();
      m_state = 0; m_len = 0; m_idx = 0; m_fc = '0; m_lenerr = 1'b0;
    end else begin
      exp_valid = mq.size() > 0;
      exp_ready = (m_state == 1) && (mq.size() < 2);
      exp_busy  = (m_state != 0) || (mq.size() > 0);
      check("m_tvalid", 64'(m_tvalid), 64'(exp_valid));
      if (exp_valid && m_tvalid) begin
        check("m_tdata", 64'(m_tdata), 64'(mq[0].data));
        check("m_tuser", 64'(m_tuser), 64'(mq[0].user));
        check("m_tlast", 64'(m_tlast), 64'(mq[0].last));
      end
      check("s_tready", 64'(s_tready), 64'(exp_ready));
      check("busy", 64'(busy), 64'(exp_busy));
      check("len_err", 64'(len_err), 64'(m_lenerr));
      check("frame_count", 64'(frame_count), 64'(m_fc));

      in_acc   = s_tvalid && exp_ready;
      out_hs   = exp_valid && m_tready;
      pre_size = mq.size();
      if (out_hs) begin
        b = mq.pop_front();
        obs.push_back(b);
        if (b.last) m_fc = m_fc + 1'b1;
      end
      last_in = 1'b0;
      if (in_acc) begin
        b.data = model_data(s_tdata);
        b.user = (m_idx == 0);
        b.last = (m_idx == m_len - 1);
        last_in = b.last;
        mq.push_back(b);
        m_idx++;
      end
      m_lenerr = (m_state == 0) && start && (query_len == '0);
      case (m_state)
        0: if (start && query_len != '0) begin
             m_state = 1; m_len = int'(query_len); m_idx = 0;
           end
        1: if (last_in) m_state = 2;
           else if (abort) begin
             if (mq.size() == 0) begin
               b = '{data: '0, user: (m_idx == 0), last: 1'b1};
               mq.push_back(b);
             end else if (mq.size() == 1 && !out_hs && !in_acc) begin
               // the only pending beat is stalled on the bus: append a terminator
               b = '{data: '0, user: 1'b0, last: 1'b1};
               mq.push_back(b);
             end else begin
               b = mq.pop_back();
               b.last = 1'b1;
               mq.push_back(b);
             end
             m_state = 2;
           end
        default: if (pre_size == 0) m_state = 0;
      endcase
    end
  end

  // downstream ready toggles every cycle while enabled
  initial forever begin
    @(posedge clk); #1;
    if (toggle_en) m_tready = !m_tready;
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input int len);
    @(posedge clk); #1;
    start = 1'b1; query_len = LW'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int v, input bit with_abort);
    bit got = 1'b0;
    int budget = 0;
    s_tvalid = 1'b1; s_tdata = IW'(v); abort = with_abort;
    while (!got && budget < 50) begin
      @(negedge clk); got = s_tready;
      @(posedge clk); #1;
      abort = 1'b0;
      budget++;
    end
    s_tvalid = 1'b0;
    if (!got) check("feed_timeout", 64'(0), 64'(1));
  endtask

  task automatic abort_pulse();
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) check("idle_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int frames;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
    start = 1'b0; abort = 1'b0; query_len = '0; toggle_en = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_m_tdata", 64'(m_tdata), 64'(0));
    check("rst_s_tready", 64'(s_tready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_frame_count", 64'(frame_count), 64'(0));
    @(posedge clk); #1; rst_n = 1'b1;

    // basic frame, full rate
    obs.delete();
    do_start(4);
    feed(10, 0); feed(-3, 0); feed(7, 0); feed(5, 0);
    wait_idle();
    check("t1_nbeats", 64'(obs.size()), 64'(4));
    check("t1_b0_data", 64'(obs_at(0).data), 64'(10));
    check("t1_b0_user", 64'(obs_at(0).user), 64'(1));
    check("t1_b1_data", 64'(obs_at(1).data), 64'(32'hFFFF_FFFD));
    check("t1_b1_user", 64'(obs_at(1).user), 64'(0));
    check("t1_b2_last", 64'(obs_at(2).last), 64'(0));
    check("t1_b3_data", 64'(obs_at(3).data), 64'(5));
    check("t1_b3_last", 64'(obs_at(3).last), 64'(1));
    check("t1_frame_count", 64'(frame_count), 64'(1));

    // stalling downstream
    obs.delete();
    toggle_en = 1'b1;
    do_start(3);
    feed(100, 0); feed(-200, 0); feed(300, 0);
    wait_idle();
    toggle_en = 1'b0; m_tready = 1'b1;
    check("t2_nbeats", 64'(obs.size()), 64'(3));
    check("t2_b1_data", 64'(obs_at(1).data), 64'(32'hFFFF_FF38));
    check("t2_b2_last", 64'(obs_at(2).last), 64'(1));
    check("t2_b1_last", 64'(obs_at(1).last), 64'(0));

    // input while idle, then zero-length start
    @(posedge clk); #1; s_tvalid = 1'b1; s_tdata = 16'd55;
    repeat (5) begin
      @(negedge clk);
      check("t3_idle_tready", 64'(s_tready), 64'(0));
      check("t3_idle_mvalid", 64'(m_tvalid), 64'(0));
    end
    @(posedge clk); #1; s_tvalid = 1'b0; start = 1'b1; query_len = '0;
    @(negedge clk); check("t3_len_err_same", 64'(len_err), 64'(0));
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); check("t3_len_err_pulse", 64'(len_err), 64'(1));
    check("t3_busy", 64'(busy), 64'(0));
    @(negedge clk); check("t3_len_err_drop", 64'(len_err), 64'(0));

    // abort together with the 3rd accepted beat
    obs.delete();
    do_start(8);
    feed(21, 0); feed(22, 0); feed(23, 1);
    wait_idle();
    check("t4_nbeats", 64'(obs.size()), 64'(3));
    check("t4_b2_data", 64'(obs_at(2).data), 64'(23));
    check("t4_b2_last", 64'(obs_at(2).last), 64'(1));

    // abort with an empty buffer after two beats
    obs.delete();
    do_start(8);
    feed(31, 0); feed(32, 0);
    repeat (4) @(posedge clk);
    abort_pulse();
    wait_idle();
    check("t4e_nbeats", 64'(obs.size()), 64'(3));
    check("t4e_zero_data", 64'(obs_at(2).data), 64'(0));
    check("t4e_zero_user", 64'(obs_at(2).user), 64'(0));
    check("t4e_zero_last", 64'(obs_at(2).last), 64'(1));

    // abort before any input
    obs.delete();
    do_start(5);
    abort_pulse();
    wait_idle();
    check("t4i_nbeats", 64'(obs.size()), 64'(1));
    check("t4i_user", 64'(obs_at(0).user), 64'(1));
    check("t4i_last", 64'(obs_at(0).last), 64'(1));

    // abort while the only beat is stalled on the bus
    obs.delete();
    m_tready = 1'b0;
    do_start(8);
    feed(11, 0);
    repeat (3) @(posedge clk);
    abort_pulse();
    repeat (2) @(posedge clk);
    #1 m_tready = 1'b1;
    wait_idle();
    check("t4s_nbeats", 64'(obs.size()), 64'(2));
    check("t4s_b0_last", 64'(obs_at(0).last), 64'(0));
    check("t4s_b1_last", 64'(obs_at(1).last), 64'(1));

    // clamp / pass-through
    obs.delete();
    do_start(3);
    feed(3000, 0); feed(-5000, 0); feed(100, 0);
    wait_idle();
`ifdef AXIS_QUERY_FRAMER_CLAMP_EN
    check("t5_hi", 64'(obs_at(0).data), 64'(2047));
    check("t5_lo", 64'(obs_at(1).data), 64'(32'hFFFF_F800));
`else
    check("t5_hi", 64'(obs_at(0).data), 64'(3000));
    check("t5_lo", 64'(obs_at(1).data), 64'(32'hFFFF_EC78));
`endif
    check("t5_mid", 64'(obs_at(2).data), 64'(100));

    // frame_count wrap via single-beat frames
    frames = (1 << CW) - int'(m_fc);
    for (int f = 0; f < frames; f++) begin
      if (f == frames - 1) begin
        check("t6_fc_max", 64'(frame_count), 64'((1 << CW) - 1));
        obs.delete();
      end
      do_start(1);
      feed(f, 0);
      wait_idle();
    end
    check("t6_fc_wrap", 64'(frame_count), 64'(0));
    check("t6_single_user", 64'(obs_at(0).user), 64'(1));
    check("t6_single_last", 64'(obs_at(0).last), 64'(1));

    // reset mid-frame with buffered beats
    m_tready = 1'b0;
    do_start(8);
    feed(41, 0); feed(42, 0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("t7_m_tvalid", 64'(m_tvalid), 64'(0));
    check("t7_m_tdata", 64'(m_tdata), 64'(0));
    check("t7_m_tlast", 64'(m_tlast), 64'(0));
    check("t7_m_tuser", 64'(m_tuser), 64'(0));
    check("t7_s_tready", 64'(s_tready), 64'(0));
    check("t7_busy", 64'(busy), 64'(0));
    check("t7_frame_count", 64'(frame_count), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    m_tready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t7_no_beats", 64'(m_tvalid), 64'(0));
    check("model_drained", 64'(mq.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
